// File: rtl/evt_pkg.sv
// evt_pkg: shared types and constants for the event window controller
package evt_pkg;
  localparam int TS_W = 16;
  localparam logic [TS_W-1:0] DEF_WINDOW_TICKS = 16'd10000;
  localparam logic [15:0] DEF_MIN_EVENTS = 16'd32;
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, READOUT} state_e;
endpackage

// File: rtl/evt_window_ctrl.sv
// evt_window_ctrl: timestamp-window event accumulation and readout handshake
// Ports: clk/rst_n (async active-low); enable run request; fifo_valid -> dec_valid
// gated in ACCUM; evt_valid/evt_ts decoded events; win_clear one-cycle clear;
// readout_req/readout_ack classifier handshake; win_evt_cnt events in window;
// win_count windows read out; busy whenever not IDLE.
// Optional: define EVT_IDLE_TIMEOUT_EN to close a non-empty window after
// IDLE_TIMEOUT silent ACCUM cycles.
module evt_window_ctrl
  import evt_pkg::*;
#(
  parameter logic [TS_W-1:0] WINDOW_TICKS = DEF_WINDOW_TICKS,
  parameter logic [15:0]     MIN_EVENTS   = DEF_MIN_EVENTS,
  parameter logic [19:0]     IDLE_TIMEOUT = 20'd500000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            fifo_valid,
  output logic            dec_valid,
  input  logic            evt_valid,
  input  logic [TS_W-1:0] evt_ts,
  output logic            win_clear,
  output logic            readout_req,
  input  logic            readout_ack,
  output logic [15:0]     win_evt_cnt,
  output logic [7:0]      win_count,
  output logic            busy
);
  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] wc_q, wc_d;
  logic [TS_W-1:0] start_q, start_d, elapsed;
  logic first_q, first_d, tmo_hit;
`ifdef EVT_IDLE_TIMEOUT_EN
  logic [19:0] tmo_q, tmo_d;
  // Counts silent ACCUM cycles, holding once the limit is reached.
  always_comb begin
    tmo_d = '0;
    if (state_q == ACCUM && enable && !evt_valid)
      tmo_d = (tmo_q == IDLE_TIMEOUT) ? tmo_q : tmo_q + 20'd1;
    tmo_hit = (state_q == ACCUM) && !evt_valid && (tmo_d == IDLE_TIMEOUT) && (cnt_q != 16'd0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^IDLE_TIMEOUT;
  assign tmo_hit = 1'b0;
`endif
  // Modular subtraction makes timestamp wrap-around transparent.
  assign elapsed = evt_ts - start_q;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign dec_valid = (state_q == ACCUM) && fifo_valid;
  assign win_clear = (state_q == CLEAR);
  assign readout_req = (state_q == READOUT);
  assign busy = (state_q != IDLE);
  assign win_evt_cnt = cnt_q;
  assign win_count = wc_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wc_d = wc_q;
    start_d = start_q;
    first_d = first_q;
    case (state_q)
      IDLE: state_d = enable ? CLEAR : IDLE;
      CLEAR: begin
        cnt_d = '0;
        first_d = 1'b0;
        state_d = enable ? ACCUM : IDLE;
      end
      ACCUM: begin
        if (!enable) state_d = IDLE;
        else if (evt_valid) begin
          cnt_d = cnt_inc;
          if (!first_q) begin
            start_d = evt_ts;
            first_d = 1'b1;
          end else if (elapsed >= WINDOW_TICKS) state_d = DRAIN;
        end else if (tmo_hit) state_d = DRAIN;
      end
      // One cycle to absorb the decoder's in-flight event before deciding.
      DRAIN: begin
        if (evt_valid) cnt_d = cnt_inc;
        state_d = (cnt_d >= MIN_EVENTS) ? READOUT : (enable ? CLEAR : IDLE);
      end
      READOUT: if (readout_ack) begin
        wc_d = wc_q + 8'd1;
        state_d = enable ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wc_q <= '0;
      start_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wc_q <= wc_d;
      start_q <= start_d;
      first_q <= first_d;
    end
endmodule

// File: tb/tb_evt_window_ctrl.sv
// tb_evt_window_ctrl: directed self-checking bench for evt_window_ctrl
module tb_evt_window_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, fifo_valid = 1'b1;
  logic evt_valid = 1'b0, readout_ack = 1'b0;
  logic [15:0] evt_ts = '0;
  logic dec_valid, win_clear, readout_req, busy;
  logic [15:0] win_evt_cnt;
  logic [7:0] win_count;
  int checks = 0, failures = 0;

  evt_window_ctrl #(.IDLE_TIMEOUT(20'd100)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_valid(fifo_valid),
    .dec_valid(dec_valid), .evt_valid(evt_valid), .evt_ts(evt_ts),
    .win_clear(win_clear), .readout_req(readout_req), .readout_ack(readout_ack),
    .win_evt_cnt(win_evt_cnt), .win_count(win_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic evt(input logic [15:0] ts);
    evt_valid = 1'b1;
    evt_ts = ts;
    step();
    evt_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, win_clear, readout_req, dec_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, win_clear, readout_req, dec_valid});
    end
    checks++;
    if (win_evt_cnt !== 16'd0 || win_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_counts got cnt=%0d wc=%0d exp 0/0", win_evt_cnt, win_count);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold busy=%b exp=0", busy);
    end
  endtask

  task automatic test_small_window;
    enable = 1'b1;
    step();
    checks++;
    if (win_clear !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_pulse win_clear=%b busy=%b exp 1/1", win_clear, busy);
    end
    step();
    checks++;
    if (win_clear !== 1'b0 || dec_valid !== 1'b1) begin
      failures++;
      $display("FAIL accum_entry win_clear=%b dec_valid=%b exp 0/1", win_clear, dec_valid);
    end
    evt(16'd100);
    evt(16'd5000);
    evt(16'd10100);
    checks++;
    if (dec_valid !== 1'b0 || busy !== 1'b1 || win_evt_cnt !== 16'd3) begin
      failures++;
      $display("FAIL small_drain dec_valid=%b busy=%b cnt=%0d exp 0/1/3", dec_valid, busy, win_evt_cnt);
    end
    step();
    checks++;
    if (win_clear !== 1'b1 || readout_req !== 1'b0 || win_count !== 8'd0) begin
      failures++;
      $display("FAIL small_discard clr=%b req=%b wc=%0d exp 1/0/0", win_clear, readout_req, win_count);
    end
    step();
    checks++;
    if (win_evt_cnt !== 16'd0 || dec_valid !== 1'b1) begin
      failures++;
      $display("FAIL small_reaccum cnt=%0d dec_valid=%b exp 0/1", win_evt_cnt, dec_valid);
    end
  endtask

  task automatic test_readout;
    for (int i = 0; i < 40; i++) evt(16'(i * 250));
    evt(16'd10000);
    step();
    checks++;
    if (readout_req !== 1'b1 || win_evt_cnt !== 16'd41) begin
      failures++;
      $display("FAIL readout_req req=%b cnt=%0d exp 1/41", readout_req, win_evt_cnt);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (readout_req !== 1'b1 || win_count !== 8'd0) begin
      failures++;
      $display("FAIL readout_hold req=%b wc=%0d exp 1/0", readout_req, win_count);
    end
    readout_ack = 1'b1;
    step();
    readout_ack = 1'b0;
    checks++;
    if (win_count !== 8'd1 || win_clear !== 1'b1 || readout_req !== 1'b0) begin
      failures++;
      $display("FAIL readout_ack wc=%0d clr=%b req=%b exp 1/1/0", win_count, win_clear, readout_req);
    end
    step();
  endtask

  task automatic test_wrap;
    evt(16'd65000);
    evt(16'd9463);
    checks++;
    if (dec_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_open dec_valid=%b exp=1", dec_valid);
    end
    evt(16'd9464);
    checks++;
    if (dec_valid !== 1'b0 || busy !== 1'b1 || win_evt_cnt !== 16'd3) begin
      failures++;
      $display("FAIL wrap_close dec_valid=%b busy=%b cnt=%0d exp 0/1/3", dec_valid, busy, win_evt_cnt);
    end
    step();
    step();
  endtask

  task automatic test_drain_event;
    evt(16'd0);
    readout_ack = 1'b1;
    step();
    readout_ack = 1'b0;
    checks++;
    if (dec_valid !== 1'b1 || win_count !== 8'd1 || readout_req !== 1'b0) begin
      failures++;
      $display("FAIL stray_ack dec_valid=%b wc=%0d req=%b exp 1/1/0", dec_valid, win_count, readout_req);
    end
    evt(16'd10000);
    evt(16'd10001);
    checks++;
    if (win_evt_cnt !== 16'd3 || win_clear !== 1'b1) begin
      failures++;
      $display("FAIL drain_count cnt=%0d clr=%b exp 3/1", win_evt_cnt, win_clear);
    end
    step();
  endtask

  task automatic test_enable_drop;
    for (int i = 0; i < 31; i++) evt(16'(i * 100));
    evt(16'd10000);
    step();
    checks++;
    if (readout_req !== 1'b1 || win_evt_cnt !== 16'd32) begin
      failures++;
      $display("FAIL min_readout req=%b cnt=%0d exp 1/32", readout_req, win_evt_cnt);
    end
    enable = 1'b0;
    step();
    step();
    checks++;
    if (readout_req !== 1'b1) begin
      failures++;
      $display("FAIL drop_hold req=%b exp=1", readout_req);
    end
    readout_ack = 1'b1;
    step();
    readout_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || dec_valid !== 1'b0 || win_count !== 8'd2 || win_clear !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle busy=%b dv=%b wc=%0d clr=%b exp 0/0/2/0", busy, dec_valid, win_count, win_clear);
    end
  endtask

  task automatic test_timeout;
    enable = 1'b1;
    step();
    step();
    for (int i = 1; i <= 5; i++) evt(16'(i));
    for (int i = 0; i < 99; i++) step();
    checks++;
    if (dec_valid !== 1'b1) begin
      failures++;
      $display("FAIL tmo_early dec_valid=%b exp=1", dec_valid);
    end
    step();
`ifdef EVT_IDLE_TIMEOUT_EN
    checks++;
    if (dec_valid !== 1'b0 || busy !== 1'b1 || win_clear !== 1'b0) begin
      failures++;
      $display("FAIL tmo_drain dv=%b busy=%b clr=%b exp 0/1/0", dec_valid, busy, win_clear);
    end
`else
    for (int i = 0; i < 50; i++) step();
    checks++;
    if (dec_valid !== 1'b1 || win_evt_cnt !== 16'd5) begin
      failures++;
      $display("FAIL no_tmo dv=%b cnt=%0d exp 1/5", dec_valid, win_evt_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_small_window();
    test_readout();
    test_wrap();
    test_drain_event();
    test_enable_drop();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
